// File: rtl/ram256_arb.sv
// ram256_arb: sequencer/arbiter for one 256x8 registered-read RAM.
// After reset it optionally clears every location to CLEAR_VALUE, then
// arbitrates the single RAM port between three requesters:
//   vid : read-only, fixed top priority
//   cpu : read/write, round-robin against dma
//   dma : read/write, round-robin against cpu
// Ports:
//   clk, reset                      clock (RAM rclk/wclk tied to it), async active-high reset
//   vid_req/vid_addr                video read request; vid_ack/vid_rdata completion
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request; cpu_ack/cpu_rdata completion
//   dma_req/dma_we/dma_addr/dma_wdata  DMA request; dma_ack/dma_rdata completion
//   ram_a/ram_i/ram_r/ram_w         RAM address, write data, read/write strobes
//   ram_o                           RAM registered read data
//   busy                            high while the clear is in progress
// Timing per transaction: grant at edge E0, strobes high E0..E1, ack and
// rdata at E2. A requester stays ineligible from its grant edge through
// its ack edge.
module ram256_arb #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vid_req,
  input  logic [7:0] vid_addr,
  output logic       vid_ack,
  output logic [7:0] vid_rdata,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] ram_a,
  output logic [7:0] ram_i,
  output logic       ram_r,
  output logic       ram_w,
  input  logic [7:0] ram_o,
  output logic       busy
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_DMA} src_t;

  state_t     state, state_nxt;
  logic [7:0] clr_cnt;

  // outstanding flags: set at grant, cleared at the ack edge
  logic out_vid, out_cpu, out_dma;
  // 1: cpu wins the next cpu/dma tie
  logic rr_cpu;

  // issue stage (strobe cycle) and completion stage (ram_o valid cycle)
  logic s1_vld, s1_we;
  src_t s1_src;
  logic s2_vld, s2_we;
  src_t s2_src;

  logic       el_vid, el_cpu, el_dma;
  logic       gnt_any, gnt_we;
  src_t       gnt_src;
  logic [7:0] gnt_addr, gnt_wdata;

  always_comb begin
    el_vid    = vid_req & ~out_vid;
    el_cpu    = cpu_req & ~out_cpu;
    el_dma    = dma_req & ~out_dma;
    state_nxt = state;
    gnt_any   = 1'b0;
    gnt_we    = 1'b0;
    gnt_src   = SRC_VID;
    gnt_addr  = '0;
    gnt_wdata = '0;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == 8'hFF) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (el_vid) begin
          gnt_any  = 1'b1;
          gnt_src  = SRC_VID;
          gnt_addr = vid_addr;
        end else if (el_cpu && (!el_dma || rr_cpu)) begin
          gnt_any   = 1'b1;
          gnt_src   = SRC_CPU;
          gnt_we    = cpu_we;
          gnt_addr  = cpu_addr;
          gnt_wdata = cpu_wdata;
        end else if (el_dma) begin
          gnt_any   = 1'b1;
          gnt_src   = SRC_DMA;
          gnt_we    = dma_we;
          gnt_addr  = dma_addr;
          gnt_wdata = dma_wdata;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      busy      <= CLEAR_ON_RESET;
      clr_cnt   <= '0;
      rr_cpu    <= 1'b1;
      out_vid   <= 1'b0;
      out_cpu   <= 1'b0;
      out_dma   <= 1'b0;
      s1_vld    <= 1'b0;
      s1_we     <= 1'b0;
      s1_src    <= SRC_VID;
      s2_vld    <= 1'b0;
      s2_we     <= 1'b0;
      s2_src    <= SRC_VID;
      ram_a     <= '0;
      ram_i     <= '0;
      ram_r     <= 1'b0;
      ram_w     <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      vid_rdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state   <= state_nxt;
      // busy drops one edge after the last clear write is launched,
      // i.e. at the edge that ends the write to location 255
      busy    <= (state == ST_CLEAR);
      ram_r   <= 1'b0;
      ram_w   <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      s1_vld  <= 1'b0;

      if (state == ST_CLEAR) begin
        ram_w   <= 1'b1;
        ram_a   <= clr_cnt;
        ram_i   <= CLEAR_VALUE;
        clr_cnt <= clr_cnt + 8'd1;
      end

      if (gnt_any) begin
        s1_vld <= 1'b1;
        s1_we  <= gnt_we;
        s1_src <= gnt_src;
        ram_a  <= gnt_addr;
        if (gnt_we) begin
          ram_w <= 1'b1;
          ram_i <= gnt_wdata;
        end else begin
          ram_r <= 1'b1;
        end
        case (gnt_src)
          SRC_CPU: begin out_cpu <= 1'b1; rr_cpu <= 1'b0; end
          SRC_DMA: begin out_dma <= 1'b1; rr_cpu <= 1'b1; end
          default: out_vid <= 1'b1;
        endcase
      end

      s2_vld <= s1_vld;
      s2_we  <= s1_we;
      s2_src <= s1_src;

      if (s2_vld) begin
        case (s2_src)
          SRC_CPU: begin
            cpu_ack <= 1'b1;
            out_cpu <= 1'b0;
            if (!s2_we) cpu_rdata <= ram_o;
          end
          SRC_DMA: begin
            dma_ack <= 1'b1;
            out_dma <= 1'b0;
            if (!s2_we) dma_rdata <= ram_o;
          end
          default: begin
            vid_ack   <= 1'b1;
            out_vid   <= 1'b0;
            vid_rdata <= ram_o;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram256_arb.sv
// Testbench for ram256_arb: behavioural 256x8 registered-read RAM attached
// to the RAM port, directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.
module tb_ram256_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vid_req = 1'b0;
  logic [7:0] vid_addr = '0;
  logic       vid_ack;
  logic [7:0] vid_rdata;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = '0, dma_wdata = '0;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] ram_a, ram_i, ram_o;
  logic       ram_r, ram_w, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram256_arb #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_a(ram_a), .ram_i(ram_i), .ram_r(ram_r), .ram_w(ram_w), .ram_o(ram_o),
    .busy(busy)
  );

  // behavioural RAM
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_w) mem[ram_a] <= ram_i;
    if (ram_r) ram_o <= mem[ram_a];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drop_all();
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drop_all();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int wcnt, bcnt, rcnt;
    wcnt = 0; bcnt = 0; rcnt = 0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({vid_ack, cpu_ack, dma_ack, ram_r, ram_w, busy, ram_a, ram_i, vid_rdata, cpu_rdata, dma_rdata}
        !== {5'b00000, 1'b1, 40'd0}) begin
      bad++;
      $display("FAIL reset_values: got ack=%b%b%b r=%b w=%b busy=%b a=%h i=%h rd=%h/%h/%h, want all zero busy=1",
               vid_ack, cpu_ack, dma_ack, ram_r, ram_w, busy, ram_a, ram_i, vid_rdata, cpu_rdata, dma_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (ram_r) rcnt++;
      if (ram_w) begin
        total++;
        if (ram_a !== 8'(wcnt) || ram_i !== 8'hA5) begin
          bad++;
          $display("FAIL clear_write: write #%0d got a=%h i=%h, want a=%h i=a5", wcnt, ram_a, ram_i, 8'(wcnt));
        end
        wcnt++;
      end
    end
    total++;
    if (wcnt != 256) begin bad++; $display("FAIL clear_count: got %0d writes, want 256", wcnt); end
    total++;
    if (bcnt != 256) begin bad++; $display("FAIL busy_cycles: got %0d, want 256", bcnt); end
    total++;
    if (rcnt != 0) begin bad++; $display("FAIL clear_reads: got %0d read strobes, want 0", rcnt); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] ackv [1:8];
    logic [9:0] iss  [1:8];
    logic [2:0] eack [1:8];
    logic [9:0] eiss [1:8];
    logic [7:0] vrd, crd, wd;
    vrd = '0; crd = '0; wd = '0;
    for (int j = 1; j <= 8; j++) begin eack[j] = 3'b000; eiss[j] = 10'd0; end
    eiss[1] = {2'b10, 8'h12}; eiss[2] = {2'b10, 8'h37}; eiss[3] = {2'b01, 8'h40};
    eack[3] = 3'b100; eack[4] = 3'b010; eack[5] = 3'b001;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 8'h12;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h37;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h77;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      ackv[j] = {vid_ack, cpu_ack, dma_ack};
      iss[j]  = {ram_r, ram_w, ram_a};
      if (ram_w) wd = ram_i;
      if (vid_ack) begin vrd = vid_rdata; vid_req = 1'b0; end
      if (cpu_ack) begin crd = cpu_rdata; cpu_req = 1'b0; end
      if (dma_ack) dma_req = 1'b0;
    end
    for (int j = 1; j <= 8; j++) begin
      total++;
      if (ackv[j] !== eack[j]) begin
        bad++; $display("FAIL simul_ack: cycle %0d got vcd=%b want %b", j, ackv[j], eack[j]);
      end
      total++;
      if ((eiss[j][9:8] == 2'b00) ? (iss[j][9:8] !== 2'b00) : (iss[j] !== eiss[j])) begin
        bad++; $display("FAIL simul_issue: cycle %0d got rw=%b a=%h want rw=%b a=%h",
                        j, iss[j][9:8], iss[j][7:0], eiss[j][9:8], eiss[j][7:0]);
      end
    end
    total++;
    if (vrd !== 8'hA5) begin bad++; $display("FAIL simul_vid_rdata: got %h want a5", vrd); end
    total++;
    if (crd !== 8'hA5) begin bad++; $display("FAIL simul_cpu_rdata: got %h want a5", crd); end
    total++;
    if (wd !== 8'h77) begin bad++; $display("FAIL simul_dma_wdata: got %h want 77", wd); end
  endtask

  task automatic cpu_xact(input logic we, input logic [7:0] a, input logic [7:0] wd,
                          output int g, output int k, output logic [7:0] rd, output logic saw);
    g = -1; k = -1; rd = '0; saw = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      if (g < 0 && (ram_r || ram_w) && ram_a == a) begin
        g = j;
        saw = we ? (ram_w && !ram_r && ram_i == wd) : (ram_r && !ram_w);
      end
      if (cpu_ack) begin k = j; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_wr_rd();
    int g, k;
    logic [7:0] rd, v0, d0;
    logic saw;
    v0 = vid_rdata; d0 = dma_rdata;
    cpu_xact(1'b0, 8'h37, 8'h00, g, k, rd, saw);
    total++;
    if (g != 1 || k - g != 2 || rd !== 8'hA5 || !saw) begin
      bad++; $display("FAIL cpu_read_clear: grant=%0d ack=%0d rd=%h strobe=%b, want 1 3 a5 1", g, k, rd, saw);
    end
    cpu_xact(1'b1, 8'h12, 8'h5C, g, k, rd, saw);
    total++;
    if (k - g != 2 || !saw) begin
      bad++; $display("FAIL cpu_write: grant=%0d ack=%0d strobe=%b, want ack=grant+2 strobe=1", g, k, saw);
    end
    total++;
    if (rd !== 8'hA5) begin bad++; $display("FAIL cpu_write_rdata_hold: got %h want a5", rd); end
    cpu_xact(1'b0, 8'h12, 8'h00, g, k, rd, saw);
    total++;
    if (k - g != 2 || rd !== 8'h5C) begin
      bad++; $display("FAIL cpu_readback: grant=%0d ack=%0d rd=%h, want ack=grant+2 rd=5c", g, k, rd);
    end
    cpu_xact(1'b0, 8'h40, 8'h00, g, k, rd, saw);
    total++;
    if (rd !== 8'h77) begin bad++; $display("FAIL cpu_read_dma_data: got %h want 77", rd); end
    total++;
    if (vid_rdata !== v0 || dma_rdata !== d0) begin
      bad++; $display("FAIL other_rdata: vid=%h dma=%h, want %h %h", vid_rdata, dma_rdata, v0, d0);
    end
  endtask

  task automatic test_round_robin();
    int prev, src, nc, nd;
    prev = -1; nc = 0; nd = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h85;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h05;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (ram_r || ram_w) begin
        src = ram_a[7] ? 1 : 2;
        if (prev >= 0) begin
          total++;
          if (src == prev) begin
            bad++; $display("FAIL rr_alternate: cycle %0d got src=%0d twice, want alternating", j, src);
          end
        end
        prev = src;
        if (src == 1) nc++; else nd++;
      end
    end
    drop_all();
    repeat (4) @(posedge clk);
    total++;
    if (nc != 10 || nd != 10) begin
      bad++; $display("FAIL rr_counts: got cpu=%0d dma=%0d, want 10 10", nc, nd);
    end
  endtask

  task automatic test_req_hold();
    logic [1:0] got, want;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h33;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      got  = {(ram_w && ram_a == 8'h20), cpu_ack};
      want = {(j % 3 == 1), (j % 3 == 0)};
      if (j == 12) cpu_req = 1'b0;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL req_hold: cycle %0d got issue/ack=%b want %b", j, got, want);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midop();
    logic seen;
    int to;
    seen = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    @(posedge clk); #1;
    total++;
    if (ram_r !== 1'b1) begin bad++; $display("FAIL midop_issue: ram_r=%b want 1", ram_r); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({vid_ack, cpu_ack, dma_ack, ram_r, ram_w, busy, ram_a, ram_i, vid_rdata, cpu_rdata, dma_rdata}
        !== {5'b00000, 1'b1, 40'd0}) begin
      bad++;
      $display("FAIL midop_reset_values: got ack=%b%b%b r=%b w=%b busy=%b a=%h i=%h rd=%h/%h/%h, want all zero busy=1",
               vid_ack, cpu_ack, dma_ack, ram_r, ram_w, busy, ram_a, ram_i, vid_rdata, cpu_rdata, dma_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) seen = 1'b1;
      if (k < 4) begin
        total++;
        if (ram_w !== 1'b1 || ram_a !== 8'(k)) begin
          bad++; $display("FAIL midop_clear_restart: cycle %0d got w=%b a=%h want w=1 a=%h", k, ram_w, ram_a, 8'(k));
        end
      end
    end
    total++;
    if (seen) begin bad++; $display("FAIL midop_no_ack: got cpu_ack=1 want 0"); end
    to = 0;
    while (busy && to < 400) begin @(posedge clk); #1; to++; end
    total++;
    if (busy) begin bad++; $display("FAIL midop_busy_timeout: busy=1 after %0d cycles, want 0", to); end
  endtask

  // requester stimulus, index 0=vid 1=cpu 2=dma
  logic       rq  [3];
  logic       rwe [3];
  logic [7:0] rad [3];
  logic [7:0] rwd [3];

  task automatic apply();
    vid_req = rq[0]; vid_addr = rad[0];
    cpu_req = rq[1]; cpu_we = rwe[1]; cpu_addr = rad[1]; cpu_wdata = rwd[1];
    dma_req = rq[2]; dma_we = rwe[2]; dma_addr = rad[2]; dma_wdata = rwd[2];
  endtask

  task automatic test_random();
    logic [7:0] ref_mem [256];
    bit         mout [3];
    int         due  [3];
    logic [7:0] erd  [3];
    bit         ewe  [3];
    bit         acked[3];
    bit         el   [3];
    bit         mrr_cpu;
    logic [2:0] eack, aack;
    logic [7:0] ard;
    int         g, to;
    logic       gwe;
    do_reset();
    to = 0;
    while (busy && to < 400) begin @(posedge clk); #1; to++; end
    total++;
    if (busy) begin bad++; $display("FAIL rand_busy_timeout: busy=1 after %0d cycles, want 0", to); end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hA5;
    for (int r = 0; r < 3; r++) begin
      mout[r] = 1'b0; due[r] = -1; erd[r] = '0; ewe[r] = 1'b0; acked[r] = 1'b0;
      rq[r] = 1'b0; rwe[r] = 1'b0; rad[r] = '0; rwd[r] = '0;
    end
    mrr_cpu = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        if ((!rq[r] || acked[r]) && ($urandom_range(0, 3) != 0)) begin
          if (rq[r] && $urandom_range(0, 1) == 0) rq[r] = 1'b0;
          else begin
            rq[r]  = 1'b1;
            rwe[r] = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rad[r] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            rwd[r] = 8'($urandom);
          end
        end else if (acked[r]) rq[r] = 1'b0;
      end
      apply();
      @(posedge clk);
      for (int r = 0; r < 3; r++) el[r] = rq[r] && !mout[r];
      g = -1;
      if (el[0]) g = 0;
      else if (el[1] && el[2]) g = mrr_cpu ? 1 : 2;
      else if (el[1]) g = 1;
      else if (el[2]) g = 2;
      for (int r = 0; r < 3; r++) begin
        eack[2 - r] = mout[r] && (due[r] == n);
        acked[r] = eack[2 - r];
        if (acked[r]) mout[r] = 1'b0;
      end
      gwe = 1'b0;
      if (g >= 0) begin
        gwe = rwe[g];
        mout[g] = 1'b1;
        due[g] = n + 2;
        ewe[g] = gwe;
        if (gwe) ref_mem[rad[g]] = rwd[g];
        else erd[g] = ref_mem[rad[g]];
        if (g == 1) mrr_cpu = 1'b0;
        else if (g == 2) mrr_cpu = 1'b1;
      end
      #1;
      aack = {vid_ack, cpu_ack, dma_ack};
      total++;
      if (aack !== eack) begin
        bad++; $display("FAIL rand_ack: edge %0d got vcd=%b want %b", n, aack, eack);
      end
      for (int r = 0; r < 3; r++) begin
        if (acked[r] && !ewe[r]) begin
          ard = (r == 0) ? vid_rdata : (r == 1) ? cpu_rdata : dma_rdata;
          total++;
          if (ard !== erd[r]) begin
            bad++; $display("FAIL rand_rdata: edge %0d req %0d got %h want %h", n, r, ard, erd[r]);
          end
        end
      end
      total++;
      if (g < 0) begin
        if ({ram_r, ram_w} !== 2'b00) begin
          bad++; $display("FAIL rand_idle: edge %0d got rw=%b want 00", n, {ram_r, ram_w});
        end
      end else if ({ram_r, ram_w} !== {!gwe, gwe} || ram_a !== rad[g] || (gwe && ram_i !== rwd[g])) begin
        bad++; $display("FAIL rand_issue: edge %0d req %0d got rw=%b a=%h i=%h want rw=%b a=%h i=%h",
                        n, g, {ram_r, ram_w}, ram_a, ram_i, {!gwe, gwe}, rad[g], rwd[g]);
      end
    end
    drop_all();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_cpu_wr_rd();
    test_round_robin();
    test_req_hold();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
